// File: rtl/bypass_regfile_pkg.sv
// Shared core constants for the bypassing register file.
// Default geometry, zero-register index and address-width helper.
package bypass_regfile_pkg;

    localparam int RF_WIDTH    = 64;
    localparam int RF_DEPTH    = 32;
    localparam int RF_ZERO_REG = RF_DEPTH - 1;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bypass_regfile_if.sv
// Read, write and issue bundle of the bypassing register file.
// master drives addresses/writes/issue; slave returns data and busy.
interface bypass_regfile_if
    import bypass_regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int AW = addr_width(DEPTH);

    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR-1:0][AW-1:0]    wr_addr;
    logic [NUM_WR-1:0][WIDTH-1:0] wr_data;
    logic                         iss_en;
    logic [AW-1:0]                iss_addr;
    logic                         stall;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, stall
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, stall
    );

endinterface

// File: rtl/bypass_regfile_read_port.sv
// One read port: zero-register masking, write bypass, busy masking.
// Highest-numbered matching write port wins the bypass.
module regfile_read_port #(
    parameter int WIDTH  = 64,
    parameter int AW     = 5,
    parameter int NUM_WR = 2
) (
    input  logic                         valid,
    input  logic [AW-1:0]                rd_addr,
    input  logic [WIDTH-1:0]             stored,
    input  logic                         busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
    input  logic [NUM_WR-1:0][WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_busy
);

    logic             hit;
    logic [WIDTH-1:0] byp;

    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && wr_addr[i] == rd_addr) begin
                hit = 1'b1;
                byp = wr_data[i];
            end
        end
        if (!valid)
            rd_data = '0;
        else if (hit)
            rd_data = byp;
        else
            rd_data = stored;
        rd_busy = valid && busy && !hit;
    end

endmodule

// File: rtl/bypass_regfile.sv
// Multi-port register file with write bypass and hardwired zero reg.
// Scoreboard busy bits only when BYPASS_REGFILE_SCOREBOARD_EN is defined.
module bypass_regfile
    import bypass_regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = DEPTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    bypass_regfile_if.slave  bus
);

    localparam int AW = addr_width(DEPTH);

    // Real storage address: in range and not the zero register.
    function automatic logic live(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
    endfunction

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++)
                regs[r] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++)
                if (bus.wr_en[i] && live(bus.wr_addr[i]))
                    regs[bus.wr_addr[i]] <= bus.wr_data[i];
        end
    end

    logic [NUM_RD-1:0] port_busy;

`ifdef BYPASS_REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Clear on write first, then issue sets, so issue wins a tie.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_WR; i++)
            if (bus.wr_en[i] && live(bus.wr_addr[i]))
                busy_d[bus.wr_addr[i]] = 1'b0;
        if (bus.iss_en && live(bus.iss_addr))
            busy_d[bus.iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    always_comb begin
        port_busy = '0;
        for (int j = 0; j < NUM_RD; j++)
            if (live(bus.rd_addr[j]))
                port_busy[j] = busy_q[bus.rd_addr[j]];
    end
`else
    wire unused_iss = ^{bus.iss_en, bus.iss_addr};
    assign port_busy = '0;
`endif

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic             valid;
        logic [WIDTH-1:0] stored;

        assign valid  = live(bus.rd_addr[j]);
        assign stored = valid ? regs[bus.rd_addr[j]] : '0;

        regfile_read_port #(
            .WIDTH  (WIDTH),
            .AW     (AW),
            .NUM_WR (NUM_WR)
        ) u_port (
            .valid   (valid),
            .rd_addr (bus.rd_addr[j]),
            .stored  (stored),
            .busy    (port_busy[j]),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rd_data (bus.rd_data[j]),
            .rd_busy (bus.rd_busy[j])
        );
    end

    assign bus.stall = |bus.rd_busy;

endmodule

// File: tb/tb_bypass_regfile.sv
// Directed table plus randomized run against a behavioural model.
// Busy expectations follow BYPASS_REGFILE_SCOREBOARD_EN.
module tb_bypass_regfile;

`ifdef BYPASS_REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    localparam int ZR = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bypass_regfile_if #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus ();

    bypass_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [63:0] wd [2];
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra [2];

    logic [63:0] mreg [32];
    bit          mbusy [32];

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [63:0] wd0, wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0, ra1;
        logic [63:0] d0, d1;
        logic        b0, b1;
    } vec_t;

    vec_t tbl [13];

    task automatic cmp(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = '0;
        wa[0] = '0; wa[1] = '0;
        wd[0] = '0; wd[1] = '0;
        ie = 1'b0; ia = '0;
        ra[0] = '0; ra[1] = '0;
    endtask

    task automatic apply();
        bus.wr_en      = we;
        bus.wr_addr[0] = wa[0];
        bus.wr_addr[1] = wa[1];
        bus.wr_data[0] = wd[0];
        bus.wr_data[1] = wd[1];
        bus.iss_en     = ie;
        bus.iss_addr   = ia;
        bus.rd_addr[0] = ra[0];
        bus.rd_addr[1] = ra[1];
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mreg[r]  = '0;
            mbusy[r] = 1'b0;
        end
    endtask

    function automatic bit m_hit(input logic [4:0] a);
        return (we[0] && wa[0] == a) || (we[1] && wa[1] == a);
    endfunction

    function automatic logic [63:0] m_data(input logic [4:0] a);
        if (a == ZR) return '0;
        if (we[1] && wa[1] == a) return wd[1];
        if (we[0] && wa[0] == a) return wd[0];
        return mreg[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        return SB && a != ZR && mbusy[a] && !m_hit(a);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++)
            if (we[i] && wa[i] != ZR) begin
                mreg[wa[i]]  = wd[i];
                mbusy[wa[i]] = 1'b0;
            end
        if (ie && ia != ZR) mbusy[ia] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        apply();
        rst_n = 1'b0;
        model_clear();
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        //            we     wa0 wa1 wd0      wd1      ie ia ra0 ra1 d0       d1       b0 b1
        tbl[0]  = '{2'b01, 3,  0,  64'h1234, 64'h0,   0, 0, 3,  0,  64'h1234, 64'h0,   0, 0};
        tbl[1]  = '{2'b00, 0,  0,  64'h0,    64'h0,   0, 0, 3,  3,  64'h1234, 64'h1234, 0, 0};
        tbl[2]  = '{2'b11, 5,  5,  64'hAAAA, 64'h5555,0, 0, 5,  3,  64'h5555, 64'h1234, 0, 0};
        tbl[3]  = '{2'b00, 0,  0,  64'h0,    64'h0,   0, 0, 5,  31, 64'h5555, 64'h0,   0, 0};
        tbl[4]  = '{2'b01, 31, 0,  64'hFFFF, 64'h0,   1, 31,31, 5,  64'h0,    64'h5555, 0, 0};
        tbl[5]  = '{2'b00, 0,  0,  64'h0,    64'h0,   1, 7, 31, 7,  64'h0,    64'h0,   0, 0};
        tbl[6]  = '{2'b00, 0,  0,  64'h0,    64'h0,   0, 0, 7,  3,  64'h0,    64'h1234, 1, 0};
        tbl[7]  = '{2'b10, 0,  7,  64'h0,    64'h77,  0, 0, 7,  7,  64'h77,   64'h77,  0, 0};
        tbl[8]  = '{2'b00, 0,  0,  64'h0,    64'h0,   0, 0, 7,  31, 64'h77,   64'h0,   0, 0};
        tbl[9]  = '{2'b01, 9,  0,  64'h99,   64'h0,   1, 9, 9,  9,  64'h99,   64'h99,  0, 0};
        tbl[10] = '{2'b00, 0,  0,  64'h0,    64'h0,   0, 0, 9,  3,  64'h99,   64'h1234, 1, 0};
        tbl[11] = '{2'b11, 9,  2,  64'h1,    64'h22,  0, 0, 9,  2,  64'h1,    64'h22,  0, 0};
        tbl[12] = '{2'b00, 0,  0,  64'h0,    64'h0,   0, 0, 9,  2,  64'h1,    64'h22,  0, 0};

        do_reset();

        ra[0] = 5'd3; ra[1] = 5'd7;
        apply();
        #1;
        cmp("reset_d0", bus.rd_data[0], 64'h0);
        cmp("reset_d1", bus.rd_data[1], 64'h0);
        cmp("reset_stall", {63'h0, bus.stall}, 64'h0);

        for (int k = 0; k < 13; k++) begin
            logic exp_b0, exp_b1;
            we = tbl[k].we;
            wa[0] = tbl[k].wa0; wa[1] = tbl[k].wa1;
            wd[0] = tbl[k].wd0; wd[1] = tbl[k].wd1;
            ie = tbl[k].ie; ia = tbl[k].ia;
            ra[0] = tbl[k].ra0; ra[1] = tbl[k].ra1;
            apply();
            #1;
            exp_b0 = tbl[k].b0 & SB;
            exp_b1 = tbl[k].b1 & SB;
            cmp($sformatf("tbl%0d_d0", k), bus.rd_data[0], tbl[k].d0);
            cmp($sformatf("tbl%0d_d1", k), bus.rd_data[1], tbl[k].d1);
            cmp($sformatf("tbl%0d_b0", k), {63'h0, bus.rd_busy[0]}, {63'h0, exp_b0});
            cmp($sformatf("tbl%0d_b1", k), {63'h0, bus.rd_busy[1]}, {63'h0, exp_b1});
            cmp($sformatf("tbl%0d_stall", k), {63'h0, bus.stall},
                {63'h0, exp_b0 | exp_b1});
            tick();
        end

        // Reset asserted mid-cycle clears contents and busy at once.
        do_reset();
        idle();
        we = 2'b01; wa[0] = 5'd2; wd[0] = 64'h22;
        ie = 1'b1; ia = 5'd4;
        apply();
        tick();
        idle();
        ra[0] = 5'd2; ra[1] = 5'd4;
        apply();
        #1;
        cmp("pre_rst_r2", bus.rd_data[0], 64'h22);
        cmp("pre_rst_busy4", {63'h0, bus.rd_busy[1]}, {63'h0, SB});
        we = 2'b01; wa[0] = 5'd6; wd[0] = 64'hCAFE;
        ra[1] = 5'd6;
        apply();
        #1 rst_n = 1'b0;
        #1;
        cmp("rst_r2", bus.rd_data[0], 64'h0);
        cmp("rst_bypass", bus.rd_data[1], 64'hCAFE);
        cmp("rst_busy0", {63'h0, bus.rd_busy[0]}, 64'h0);
        cmp("rst_stall", {63'h0, bus.stall}, 64'h0);
        ra[1] = 5'd4;
        ie = 1'b1; ia = 5'd4;
        apply();
        #1;
        cmp("rst_busy4", {63'h0, bus.rd_busy[1]}, 64'h0);
        tick();
        idle();
        ra[0] = 5'd6; ra[1] = 5'd4;
        apply();
        #2 rst_n = 1'b1;
        #1;
        cmp("post_rst_r6", bus.rd_data[0], 64'h0);
        cmp("post_rst_busy4", {63'h0, bus.rd_busy[1]}, 64'h0);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            we    = 2'($urandom_range(0, 3));
            wa[0] = 5'($urandom_range(0, 31));
            wa[1] = ($urandom_range(0, 3) == 0) ? wa[0] : 5'($urandom_range(0, 31));
            wd[0] = {$urandom, $urandom};
            wd[1] = {$urandom, $urandom};
            ie    = 1'($urandom_range(0, 1));
            ia    = 5'($urandom_range(0, 31));
            ra[0] = ($urandom_range(0, 2) == 0) ? wa[0] : 5'($urandom_range(0, 31));
            ra[1] = ($urandom_range(0, 2) == 0) ? wa[1] : 5'($urandom_range(0, 31));
            apply();
            #1;
            cmp($sformatf("rnd%0d_d0", c), bus.rd_data[0], m_data(ra[0]));
            cmp($sformatf("rnd%0d_d1", c), bus.rd_data[1], m_data(ra[1]));
            cmp($sformatf("rnd%0d_b0", c), {63'h0, bus.rd_busy[0]},
                {63'h0, m_busy(ra[0])});
            cmp($sformatf("rnd%0d_b1", c), {63'h0, bus.rd_busy[1]},
                {63'h0, m_busy(ra[1])});
            cmp($sformatf("rnd%0d_stall", c), {63'h0, bus.stall},
                {63'h0, m_busy(ra[0]) | m_busy(ra[1])});
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
